// File: rtl/fifo_sync_ctrl_if.sv
// Producer/consumer/memory-port bundle for fifo_sync_ctrl.
// The slave modport is the controller side; master is the surrounding environment.
interface fifo_sync_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                i_push;
  logic [DATASIZE-1:0] i_wdata;
  logic                o_full;
  logic                o_afull;
  logic                o_overflow;
  logic [ADDRSIZE:0]   o_level;
  logic [DATASIZE-1:0] o_mem_wdata;
  logic [ADDRSIZE-1:0] o_mem_waddr;
  logic                o_mem_wen;
  logic                o_mem_wfull;
  logic [ADDRSIZE-1:0] o_mem_raddr;
  logic [DATASIZE-1:0] i_mem_rdata;
  logic                o_rvalid;
  logic                i_rready;
  logic [DATASIZE-1:0] o_rdata;

  modport slave (
    input  i_push, i_wdata, i_mem_rdata, i_rready,
    output o_full, o_afull, o_overflow, o_level,
           o_mem_wdata, o_mem_waddr, o_mem_wen, o_mem_wfull, o_mem_raddr,
           o_rvalid, o_rdata
  );

  modport master (
    output i_push, i_wdata, i_mem_rdata, i_rready,
    input  o_full, o_afull, o_overflow, o_level,
           o_mem_wdata, o_mem_waddr, o_mem_wen, o_mem_wfull, o_mem_raddr,
           o_rvalid, o_rdata
  );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// FIFO pointer/flag controller with a registered FWFT output stage; push-to-o_rdata is 2 edges.
// Pushes are dropped (and flagged sticky) while full; o_rdata holds while o_rvalid && !i_rready.
module fifo_sync_ctrl #(
  parameter int DATASIZE    = 8,
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_LEVEL = 12
) (
  input logic             i_clk,
  input logic             i_rst,
  fifo_sync_ctrl_if.slave bus
);
  localparam int            PW    = ADDRSIZE + 1;
  localparam logic [PW-1:0] AFULL = PW'(AFULL_LEVEL);

  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic                overflow_q, overflow_d;
  logic                rvalid_q, rvalid_d;
  logic [DATASIZE-1:0] rdata_q, rdata_d;

  logic [PW-1:0] level;
  logic          full;
  logic          mem_empty;
  logic          accept;
  logic          load;

  // Flags come only from registered pointers, so a same-edge load never rescues a push at full.
  always_comb begin
    level     = wptr_q - rptr_q;
    mem_empty = (wptr_q == rptr_q);
    full      = (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]) &&
                (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);
    accept    = bus.i_push && !full;
    load      = !mem_empty && (!rvalid_q || bus.i_rready);
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    if (accept) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (bus.i_push && full) begin
      overflow_d = 1'b1;
    end
    if (load) begin
      rptr_d   = rptr_q + PW'(1);
      rdata_d  = bus.i_mem_rdata;
      rvalid_d = 1'b1;
    end else if (rvalid_q && bus.i_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.o_level     = level;
  assign bus.o_full      = full;
  assign bus.o_afull     = (level >= AFULL);
  assign bus.o_overflow  = overflow_q;
  assign bus.o_mem_wdata = bus.i_wdata;
  assign bus.o_mem_waddr = wptr_q[ADDRSIZE-1:0];
  assign bus.o_mem_wen   = bus.i_push;
  assign bus.o_mem_wfull = full;
  assign bus.o_mem_raddr = rptr_q[ADDRSIZE-1:0];
  assign bus.o_rvalid    = rvalid_q;
  assign bus.o_rdata     = rdata_q;
endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
Single-clock pointer/flag controller and first-word-fall-through output stage for the FIFO memory array. It drives the memory's write address, write enable, full flag and read address, and takes the memory's combinational read data into a registered valid/ready output stage. It sits between the producer (push interface) and the consumer (valid/ready), wrapping the memory array.

Parameters:
DATASIZE, 8, data word width in bits
ADDRSIZE, 4, memory address width; memory depth DEPTH = 2**ADDRSIZE
AFULL_LEVEL, 12, memory occupancy at or above which o_afull asserts (1..DEPTH)

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_push  input  1  write request
i_wdata  input  DATASIZE  write data
o_full  output  1  memory full; a push this cycle is dropped
o_afull  output  1  occupancy >= AFULL_LEVEL
o_overflow  output  1  sticky: push attempted while o_full
o_level  output  ADDRSIZE+1  memory occupancy, 0..DEPTH (excludes output register)
o_mem_wdata  output  DATASIZE  to memory write data (i_wdata pass-through)
o_mem_waddr  output  ADDRSIZE  to memory write address (wptr low bits)
o_mem_wen  output  1  to memory write enable (= i_push)
o_mem_wfull  output  1  to memory full gate (= o_full)
o_mem_raddr  output  ADDRSIZE  to memory read address (rptr low bits)
i_mem_rdata  input  DATASIZE  from memory, combinational read of o_mem_raddr
o_rvalid  output  1  output register holds valid data
i_rready  input  1  consumer accepts o_rdata this cycle
o_rdata  output  DATASIZE  registered read data

Behaviour:
- Clock i_clk only; reset i_rst synchronous, active-high. Reset has priority over all other events.
- Reset values: wptr=0, rptr=0, o_full=0, o_afull=0, o_overflow=0, o_level=0, o_rvalid=0, o_rdata=0. Memory contents are not cleared.
- Pointers: wptr and rptr are ADDRSIZE+1 bits binary and wrap modulo 2**(ADDRSIZE+1). Address = low ADDRSIZE bits. mem_empty = (wptr == rptr). full = (MSBs differ, low bits equal).
- o_level = wptr - rptr, computed modulo 2**(ADDRSIZE+1). o_full = (o_level == DEPTH). o_afull = (o_level >= AFULL_LEVEL). All three are combinational from the registered pointers, so they are glitch-free per cycle.
- Write: accepted = i_push && !o_full. On acceptance the memory stores i_wdata at wptr on the same edge, and wptr increments. A push while o_full is dropped, wptr holds, and o_overflow sets and stays set until reset.
- Output stage: load = !mem_empty && (!o_rvalid || i_rready). On load, o_rdata <= i_mem_rdata, rptr increments, and o_rvalid <= 1. If o_rvalid && i_rready && mem_empty, then o_rvalid <= 0. Otherwise o_rvalid and o_rdata hold. While o_rvalid && !i_rready, o_rdata is stable.
- Latency: a push accepted at edge E0 appears on o_rdata with o_rvalid=1 after edge E1, provided the stage is empty or draining. Throughput is 1 word/cycle when i_push and i_rready are both held.
- Total storage: DEPTH + 1 words (memory plus output register).
- Simultaneous push and load in one cycle: both pointers advance and o_level is unchanged. Full is decided from the registered pointers, so a push in a cycle where o_full=1 is dropped even if a load frees an entry on the same edge.
- Empty memory with a push and o_rvalid=0: no same-cycle bypass. Data is written first and loaded on the next edge.
- Wrap-around: the address wraps DEPTH-1 -> 0 seamlessly. The pointer MSB toggles every DEPTH accesses.
- Reset mid-operation: all in-flight data is discarded, and o_rvalid=0 from the cycle after the reset edge.

Test Plan:
- Reset/idle: assert i_rst for 2 cycles, then release -> o_level=0, o_full=0, o_afull=0, o_rvalid=0, o_overflow=0, o_rdata=0.
- Latency: push 0xA5 once with i_rready=1 -> o_rvalid=1 and o_rdata=0xA5 exactly one cycle after the push edge, and o_rvalid=0 the following cycle.
- Fill/overflow: i_rready=0, push 0x00..0x11 (18 words, defaults) -> 0x00 held at output, o_level reaches 16, o_afull from level 12, o_full=1, 18th push dropped, o_overflow=1 and sticky.
- Drain with backpressure: from full, toggle i_rready 1/0 -> the stream reads 0x00..0x10 in order with no duplicates; o_rdata stays stable while i_rready=0; o_full clears after the first load.
- Streaming wrap: hold i_push=1 and i_rready=1 for 40 cycles with an incrementing pattern -> o_level stays <=1, output order matches the input, and the pointers wrap past 31 correctly.
- Reset mid-operation: with o_level=7 and o_rvalid=1, pulse i_rst -> next cycle o_level=0, o_rvalid=0, o_overflow=0; a subsequent push of 0x3C is output correctly.
